// File: rtl/branch_resolve_pkg.sv
// Shared MIPS definitions used by the branch-resolution stage.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_BEQ  = 2'b01,
    OP_BNE  = 2'b10,
    OP_RSVD = 2'b11
  } branch_op_t;

  // Word offset to byte offset.
  localparam int unsigned BRANCH_SHIFT = 2;

endpackage

// File: rtl/branch_resolve_if.sv
// Decode-side request and fetch-side result bundle for branch_resolve.
interface branch_resolve_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    op;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [N-1:0]  pc_plus4;
  logic [N-1:0]  offset;
  logic          out_valid;
  logic          out_ready;
  logic          taken;
  logic [N-1:0]  target;
  logic          flush;
  logic [CW-1:0] br_count;
  logic [CW-1:0] taken_count;

  modport master (
    output in_valid, op, a, b, pc_plus4, offset, out_ready,
    input  in_ready, out_valid, taken, target, flush, br_count, taken_count
  );

  modport slave (
    input  in_valid, op, a, b, pc_plus4, offset, out_ready,
    output in_ready, out_valid, taken, target, flush, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_equality_check.sv
// Operand equality comparator shared by the branch logic.
module equality_check #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq,
  output logic         neq
);
  // Single compare, both polarities.
  always_comb begin
    eq  = (a == b);
    neq = ~eq;
  end
endmodule

// File: rtl/branch_resolve.sv
// Registered branch resolution: one-entry output stage with flush of
// wrong-path requests and saturating branch statistics.
module branch_resolve
  import mips_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input logic            clk,
  input logic            rst_n,
  branch_resolve_if.slave bus
);

  logic          eq;
  logic          neq;
  branch_op_t    op_in;
  logic          is_branch_in;
  logic          taken_in;
  logic [N-1:0]  target_in;

  logic          out_valid_q;
  logic          taken_q;
  logic [N-1:0]  target_q;
  logic          is_branch_q;
  logic [CW-1:0] br_count_q;
  logic [CW-1:0] taken_count_q;

  logic          accept;
  logic          handoff;
  logic          flush;

  equality_check #(.N(N)) u_equality_check (
    .a   (bus.a),
    .b   (bus.b),
    .eq  (eq),
    .neq (neq)
  );

  assign op_in = branch_op_t'(bus.op);

  // Decision and target for the request currently presented.
  always_comb begin
    is_branch_in = 1'b0;
    taken_in     = 1'b0;
    unique case (op_in)
      OP_BEQ: begin
        is_branch_in = 1'b1;
        taken_in     = eq;
      end
      OP_BNE: begin
        is_branch_in = 1'b1;
        taken_in     = neq;
      end
      default: begin
        is_branch_in = 1'b0;
        taken_in     = 1'b0;
      end
    endcase
    target_in = taken_in ? (bus.pc_plus4 + (bus.offset << BRANCH_SHIFT))
                         : bus.pc_plus4;
  end

  // Handshake and flush decode.
  always_comb begin
    handoff = out_valid_q && bus.out_ready;
    flush   = handoff && taken_q;
    accept  = bus.in_valid && (!out_valid_q || bus.out_ready);
  end

  // Output register; a request accepted alongside a taken handoff is wrong-path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      is_branch_q <= 1'b0;
    end else if (accept && !flush) begin
      out_valid_q <= 1'b1;
      taken_q     <= taken_in;
      target_q    <= target_in;
      is_branch_q <= is_branch_in;
    end else if (handoff) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating statistics, updated only on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else if (handoff && is_branch_q) begin
      if (br_count_q != '1)
        br_count_q <= br_count_q + CW'(1);
      if (taken_q && (taken_count_q != '1))
        taken_count_q <= taken_count_q + CW'(1);
    end
  end

  assign bus.in_ready    = !out_valid_q || bus.out_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.taken       = taken_q;
  assign bus.target      = target_q;
  assign bus.flush       = flush;
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized and directed checks of branch_resolve against a behavioural model.
module tb_branch_resolve;

  localparam int unsigned N    = 32;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  branch_resolve_if #(.N(N), .CW(CW)) bus ();

  branch_resolve #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: at most one pending result plus plain integer counters.
  bit          m_valid;
  bit          m_taken;
  logic [31:0] m_target;
  bit          m_isbr;
  int          m_br;
  int          m_tk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 2'd1) return x == y;
    if (o == 2'd2) return x != y;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_target(input bit tk, input logic [31:0] pc, input logic [31:0] off);
    logic [31:0] t;
    t = tk ? pc + off * 32'd4 : pc;
    return t;
  endfunction

  task automatic model_reset();
    m_valid  = 0;
    m_taken  = 0;
    m_target = '0;
    m_isbr   = 0;
    m_br     = 0;
    m_tk     = 0;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] pc,
                       input logic [31:0] off, input logic ordy);
    bus.in_valid  = v;
    bus.op        = o;
    bus.a         = aa;
    bus.b         = bb;
    bus.pc_plus4  = pc;
    bus.offset    = off;
    bus.out_ready = ordy;
  endtask

  // Compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    bit hs;
    bit fl;
    bit acc;
    @(negedge clk);
    check("out_valid", bus.out_valid, m_valid);
    check("in_ready", bus.in_ready, !m_valid || bus.out_ready);
    check("flush", bus.flush, m_valid && bus.out_ready && m_taken);
    if (m_valid) begin
      check("taken", bus.taken, m_taken);
      check("target", bus.target, m_target);
    end
    check("br_count", bus.br_count, m_br);
    check("taken_count", bus.taken_count, m_tk);
    if (rst_n) begin
      hs  = m_valid && bus.out_ready;
      fl  = hs && m_taken;
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      if (hs && m_isbr) begin
        m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
        if (m_taken) m_tk = (m_tk < CMAX) ? m_tk + 1 : CMAX;
      end
      if (acc && !fl) begin
        m_valid  = 1;
        m_taken  = ref_taken(bus.op, bus.a, bus.b);
        m_target = ref_target(m_taken, bus.pc_plus4, bus.offset);
        m_isbr   = (bus.op == 2'd1) || (bus.op == 2'd2);
      end else if (hs) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    model_reset();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    rst_n = 1'b0;
    #12;
    check("rst out_valid", bus.out_valid, 0);
    check("rst in_ready", bus.in_ready, 1);
    check("rst br_count", bus.br_count, 0);
    check("rst taken_count", bus.taken_count, 0);
    check("rst taken", bus.taken, 0);
    check("rst target", bus.target, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // BEQ taken, immediate consume.
    drive(1'b1, 2'd1, 32'h1234, 32'h1234, 32'h100, 32'd4, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    check("beq taken", bus.taken, 1);
    check("beq target", bus.target, 32'h110);
    check("beq flush", bus.flush, 1);
    tick();
    check("beq br_count", bus.br_count, 1);
    check("beq taken_count", bus.taken_count, 1);

    // BNE not taken.
    drive(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h200, 32'd8, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    check("bne taken", bus.taken, 0);
    check("bne target", bus.target, 32'h200);
    check("bne flush", bus.flush, 0);
    tick();
    check("bne br_count", bus.br_count, 2);
    check("bne taken_count", bus.taken_count, 1);

    // Backpressure: held three cycles while new inputs are offered.
    drive(1'b1, 2'd1, 32'd1, 32'd2, 32'h300, 32'd16, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd2, $urandom, $urandom, $urandom, $urandom, 1'b0);
      tick();
      check("bp in_ready", bus.in_ready, 0);
      check("bp target", bus.target, 32'h300);
    end
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    tick();
    tick();
    check("bp br_count", bus.br_count, 3);
    check("bp taken_count", bus.taken_count, 1);

    // Flush drop: request presented during a taken handoff is discarded.
    drive(1'b1, 2'd1, 32'd7, 32'd7, 32'h400, 32'd1, 1'b1);
    tick();
    drive(1'b1, 2'd2, 32'd1, 32'd9, 32'h500, 32'd1, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    check("drop out_valid", bus.out_valid, 0);
    tick();
    check("drop br_count", bus.br_count, 4);

    // Address wrap and negative offset.
    drive(1'b1, 2'd1, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd1, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    check("wrap target", bus.target, 32'h0);
    tick();
    drive(1'b1, 2'd2, 32'd5, 32'd6, 32'h100, 32'hFFFF_FFFF, 1'b1);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    check("neg target", bus.target, 32'hFC);
    tick();

    // Saturation with spaced taken branches.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, 32'd3, 32'd3, 32'h1000 + 32'(i), 32'(i), 1'b1);
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
      tick();
    end
    check("sat br_count", bus.br_count, CMAX);
    check("sat taken_count", bus.taken_count, CMAX);

    // Async reset while a result is held.
    drive(1'b1, 2'd1, 32'd1, 32'd1, 32'h800, 32'd2, 1'b0);
    tick();
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", bus.out_valid, 0);
    check("arst taken", bus.taken, 0);
    check("arst target", bus.target, 0);
    check("arst flush", bus.flush, 0);
    check("arst in_ready", bus.in_ready, 1);
    check("arst br_count", bus.br_count, 0);
    check("arst taken_count", bus.taken_count, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra,
            ($urandom_range(0, 1) != 0) ? ra : 32'($urandom), $urandom,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : 32'($urandom),
            1'($urandom_range(0, 3) != 0));
      tick();
    end
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered branch-resolution stage for the pipelined MIPS core. It accepts a branch request from decode over a valid/ready handshake and compares the two register operands with the existing `equality_check` comparator. It computes the branch target and hands a taken/not-taken decision, with a pipeline flush, to fetch one cycle later. It also keeps saturating branch and taken-branch counters for performance inspection.

## Interface
Parameters:
- `N`, 32, operand/address width
- `CW`, 16, statistics counter width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `op`  in  2  request type: 00 NONE, 01 BEQ, 10 BNE, 11 reserved (treated as NONE)
- `a`, `b`  in  N  operands
- `pc_plus4`  in  N  address of the next sequential instruction
- `offset`  in  N  sign-extended word offset
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `taken`  out  1  branch taken
- `target`  out  N  next PC
- `flush`  out  1  wrong-path kill to decode/fetch
- `br_count`  out  CW  branches handed off
- `taken_count`  out  CW  taken branches handed off

## Operation
- Decision rules:
  - BEQ: taken = (a == b).
  - BNE: taken = (a != b).
  - NONE/reserved: taken = 0.
- Target:
  - Taken: `target = pc_plus4 + (offset << 2)`, truncated to N bits, so wrap-around is silent.
  - Not taken: `target = pc_plus4`.
- The compare, target and op are captured into a single output register on acceptance.
- `in_ready = !out_valid || out_ready`, a one-entry pipeline with pass-through on consume. There is no internal FIFO.
- Handoff occurs when `out_valid && out_ready`. On handoff:
  - If the held op is BEQ/BNE, `br_count` increments.
  - If it was also taken, `taken_count` increments.
  - Both counters saturate at 2^CW−1 and never wrap.
- `flush = out_valid && out_ready && taken`, combinational.
- Any request accepted in the same cycle `flush` is high is wrong-path. It is dropped: `out_valid` goes 0 next cycle and counters are unaffected.
- Output and request transfer in the same cycle: the new request is loaded as the old one is handed off, with no bubble (unless it is dropped by flush).

## Timing
- Reset (async assert, sync-safe deassert): `out_valid`=0, `taken`=0, `target`=0, `br_count`=0, `taken_count`=0, so `flush`=0 and `in_ready`=1.
- Latency: request accepted in cycle t gives `out_valid`=1 in cycle t+1.
- Throughput: one request per cycle while `out_ready`=1.
- Backpressure: while `out_valid && !out_ready`:
  - `taken`, `target` and the counters are held stable.
  - `in_ready`=0.
  - Input values are ignored.
- Reset asserted mid-operation discards the held result immediately. Counters clear.
- Counter at maximum plus a handoff: it stays at maximum. `taken_count` ≤ `br_count` at all times.

## Structure
- Shared package `mips_pkg` holds:
  - `branch_op_t` enum (NONE, BEQ, BNE, RSVD) with its 2-bit encoding.
  - Constant `BRANCH_SHIFT = 2`.
- Sub-module: one instance of the existing `equality_check #(.N(N))` drives the compare. Its `eq`/`neq` outputs select by op.
- Counters are a small local always_ff block. No separate sub-module is needed.

## Test plan
- **Reset:** `rst_n`=0 → `out_valid`=0, `in_ready`=1, both counters 0. Release, then BEQ a=b=0x1234, pc_plus4=0x100, offset=4, `out_ready`=1 → next cycle `taken`=1, `target`=0x110, `flush`=1, `br_count`=1, `taken_count`=1.
- **BNE not taken:** BNE a=b=0xFFFF_FFFF, pc_plus4=0x200 → `taken`=0, `target`=0x200, `flush`=0, `br_count`+1, `taken_count` unchanged.
- **Backpressure:** BEQ a=1, b=2 with `out_ready`=0 for 3 cycles → `out_valid` stays 1, outputs stable, `in_ready`=0. Then `out_ready`=1 → one handoff, counters +1/+0.
- **Flush drop:** back-to-back BEQ taken then BNE taken (a≠b) presented in the flush cycle → second request not output, `br_count` counts only the first.
- **Wrap and negative offset:** pc_plus4=0xFFFF_FFFC, offset=1 → `target`=0x0000_0000. Also offset=0xFFFF_FFFF, pc_plus4=0x100 → `target`=0xFC.
- **Saturation:** CW=4, 20 taken branches → `br_count`=`taken_count`=15. Then async reset mid-hold → all outputs 0 in the same cycle.
